// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Covers address-width derivation, flattened-bus slicing and busy-bit next-state selection.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    typedef enum logic [1:0] {
        SbHold,
        SbSet,
        SbClear
    } sb_op_e;

    function automatic int unsigned calc_aw(input int unsigned nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    function automatic int unsigned addr_lsb(input int unsigned port, input int unsigned aw);
        return port * aw;
    endfunction

    function automatic int unsigned data_lsb(input int unsigned port, input int unsigned xlen);
        return port * xlen;
    endfunction

    // Flush beats issue, and issue beats writeback, because a new producer supersedes the old one.
    function automatic sb_op_e sb_next_op(input logic flush, input logic set, input logic clr);
        if (flush) begin
            return SbClear;
        end
        if (set) begin
            return SbSet;
        end
        if (clr) begin
            return SbClear;
        end
        return SbHold;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bundle between decode/issue/writeback (master) and the register file (slave).
// Read ports are flattened: port i uses rd_addr[i*AW +: AW] and rd_data[i*XLEN +: XLEN].
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = calc_aw(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                flush;
    logic [NREGS-1:0]    busy_vec;

    modport master (
        output rd_addr, we, wa, wd, iss_valid, iss_rd, flush,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, we, wa, wd, iss_valid, iss_rd, flush,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port: stored value, overridden by the zero register or a same-cycle
// write hit; a forwarded hit is never busy since its data is already valid.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned AW       = 5,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [AW-1:0]   i_addr,
    input  logic [XLEN-1:0] i_stored_data,
    input  logic            i_stored_busy,
    input  logic            i_we,
    input  logic [AW-1:0]   i_wa,
    input  logic [XLEN-1:0] i_wd,
    output logic [XLEN-1:0] o_data,
    output logic            o_busy
);

    logic w_is_zero;
    logic w_hit;

    assign w_is_zero = (ZERO_REG != 0) && (i_addr == '0);
    assign w_hit     = (BYPASS != 0) && i_we && (i_wa == i_addr) && !w_is_zero;

    always_comb begin
        o_data = i_stored_data;
        o_busy = i_stored_busy;
        if (w_is_zero) begin
            o_data = '0;
            o_busy = 1'b0;
        end else if (w_hit) begin
            o_data = i_wd;
            o_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with NRD combinational read ports, one write port and a
// per-register busy scoreboard set at issue and cleared at writeback or flush.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NRD      = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input logic         clk,
    input logic         reset,
    regfile_sb_if.slave sb_bus
);

    localparam int unsigned AW = calc_aw(NREGS);

    logic [NREGS-1:0][XLEN-1:0] r_regs;
    logic [NREGS-1:0]           r_busy;
    logic [NREGS-1:0]           w_busy_d;
    logic [NREGS-1:0]           w_iss_set;
    logic [NREGS-1:0]           w_wb_clr;
    logic                       w_wr_en;
    logic                       w_byp_we;

    assign w_wr_en  = sb_bus.we && !((ZERO_REG != 0) && (sb_bus.wa == '0));
    // Gate forwarding with reset so reads stay zero while reset is held.
    assign w_byp_we = sb_bus.we && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regs <= '0;
        end else if (w_wr_en) begin
            r_regs[sb_bus.wa] <= sb_bus.wd;
        end
    end

    always_comb begin
        w_iss_set = '0;
        w_wb_clr  = '0;
        if (sb_bus.iss_valid) begin
            w_iss_set[sb_bus.iss_rd] = 1'b1;
        end
        if (sb_bus.we) begin
            w_wb_clr[sb_bus.wa] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_iss_set[0] = 1'b0;
        end
    end

    always_comb begin
        w_busy_d = r_busy;
        for (int r = 0; r < NREGS; r++) begin
            case (sb_next_op(sb_bus.flush, w_iss_set[r], w_wb_clr[r]))
                SbSet:   w_busy_d[r] = 1'b1;
                SbClear: w_busy_d[r] = 1'b0;
                default: w_busy_d[r] = r_busy[r];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    assign sb_bus.busy_vec = r_busy;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_addr = sb_bus.rd_addr[addr_lsb(i, AW) +: AW];

        regfile_rdport #(
            .XLEN     (XLEN),
            .AW       (AW),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .i_addr        (w_addr),
            .i_stored_data (r_regs[w_addr]),
            .i_stored_busy (r_busy[w_addr]),
            .i_we          (w_byp_we),
            .i_wa          (sb_bus.wa),
            .i_wd          (sb_bus.wd),
            .o_data        (w_data),
            .o_busy        (w_busy)
        );

        assign sb_bus.rd_data[data_lsb(i, XLEN) +: XLEN] = w_data;
        assign sb_bus.rd_busy[i]                         = w_busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: dut A has bypass, dut B does not, both with the zero register.
// Expectations are queued as stimulus is driven and popped once the outputs have settled.
module tb_regfile_sb;

    localparam int A_D0 = 0,   A_D1 = 1,   A_B0 = 10,  A_B1 = 11,  A_V = 20;
    localparam int B_D0 = 100, B_D1 = 101, B_B0 = 110, B_B1 = 111, B_V = 120;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr0, rd_addr1;
    logic        we, iss_valid, flush;
    logic [4:0]  wa, iss_rd;
    logic [31:0] wd;

    sb_entry_t   sb_q[$];
    sb_entry_t   e;
    logic [31:0] obs;
    logic [31:0] mem [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) if_a ();
    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) if_b ();

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1), .ZERO_REG(1)) u_dut_a (
        .clk    (clk),
        .reset  (reset),
        .sb_bus (if_a)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0), .ZERO_REG(1)) u_dut_b (
        .clk    (clk),
        .reset  (reset),
        .sb_bus (if_b)
    );

    assign if_a.rd_addr = {rd_addr1, rd_addr0};
    assign if_b.rd_addr = {rd_addr1, rd_addr0};
    assign if_a.we = we;
    assign if_b.we = we;
    assign if_a.wa = wa;
    assign if_b.wa = wa;
    assign if_a.wd = wd;
    assign if_b.wd = wd;
    assign if_a.iss_valid = iss_valid;
    assign if_b.iss_valid = iss_valid;
    assign if_a.iss_rd = iss_rd;
    assign if_b.iss_rd = iss_rd;
    assign if_a.flush = flush;
    assign if_b.flush = flush;

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        int          d, w, p;
        logic [63:0] data;
        logic [1:0]  busy;
        logic [31:0] vec;
        d    = sel / 100;
        w    = (sel / 10) % 10;
        p    = sel % 10;
        data = (d == 0) ? if_a.rd_data : if_b.rd_data;
        busy = (d == 0) ? if_a.rd_busy : if_b.rd_busy;
        vec  = (d == 0) ? if_a.busy_vec : if_b.busy_vec;
        if (w == 0) return data[p*32 +: 32];
        if (w == 1) return {31'b0, busy[p]};
        return vec;
    endfunction

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        sb_q.push_back('{name: name, sel: sel, exp: exp});
    endtask

    task automatic idle();
        we = 1'b0; iss_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; rd_addr0 = 5'd5; rd_addr1 = 5'd0;
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; iss_valid = 1'b1; iss_rd = 5'd5; flush = 1'b0;
        @(negedge clk);
        #1;
        expect_val("rst_hold_data", A_D0, 32'h0);
        expect_val("rst_hold_vec", A_V, 32'h0);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
        @(negedge clk);
        reset = 1'b1; idle();
        #1;
        expect_val("rst_data_a", A_D0, 32'h0);
        expect_val("rst_busy_a", A_B0, 32'h0);
        expect_val("rst_vec_a", A_V, 32'h0);
        expect_val("rst_data_b", B_D0, 32'h0);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
    endtask

    task automatic test_write_latency();
        @(negedge clk);
        we = 1'b1; wa = 5'd3; wd = 32'h1234_5678; rd_addr0 = 5'd3; rd_addr1 = 5'd3;
        #1;
        expect_val("lat_same_b0", B_D0, 32'h0);
        expect_val("lat_same_b1", B_D1, 32'h0);
        expect_val("lat_byp_a0", A_D0, 32'h1234_5678);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
        mem[3] = 32'h1234_5678;
        @(negedge clk);
        idle();
        #1;
        expect_val("lat_next_b0", B_D0, mem[3]);
        expect_val("lat_next_b1", B_D1, mem[3]);
        expect_val("lat_next_a0", A_D0, mem[3]);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we = 1'b1; wa = 5'd7; wd = 32'hA5A5_A5A5; rd_addr0 = 5'd3; rd_addr1 = 5'd7;
        #1;
        expect_val("byp_data_a1", A_D1, 32'hA5A5_A5A5);
        expect_val("byp_busy_a1", A_B1, 32'h0);
        expect_val("nobyp_data_b1", B_D1, 32'h0);
        expect_val("byp_other_a0", A_D0, mem[3]);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
        mem[7] = 32'hA5A5_A5A5;
        @(negedge clk);
        idle();
        #1;
        expect_val("byp_stored_b1", B_D1, mem[7]);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; iss_valid = 1'b1; iss_rd = 5'd0;
        rd_addr0 = 5'd0; rd_addr1 = 5'd0;
        #1;
        expect_val("zero_same_a0", A_D0, 32'h0);
        expect_val("zero_same_b0", B_D0, 32'h0);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
        @(negedge clk);
        idle();
        for (int c = 0; c < 3; c++) begin
            #1;
            expect_val("zero_data_a0", A_D0, 32'h0);
            expect_val("zero_busy_a0", A_B0, 32'h0);
            expect_val("zero_vec_a", A_V, 32'h0);
            expect_val("zero_data_b0", B_D0, 32'h0);
            while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
                if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_rd = 5'd9; rd_addr0 = 5'd9; rd_addr1 = 5'd9;
        #1;
        expect_val("sb_iss_same_a0", A_B0, 32'h0);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
        @(negedge clk);
        idle();
        #1;
        expect_val("sb_vec_set", A_V, 32'h0000_0200);
        expect_val("sb_busy_a0", A_B0, 32'h1);
        expect_val("sb_busy_b1", B_B1, 32'h1);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
        @(negedge clk);
        we = 1'b1; wa = 5'd9; wd = 32'h42;
        #1;
        expect_val("sb_wb_data_a0", A_D0, 32'h42);
        expect_val("sb_wb_busy_a0", A_B0, 32'h0);
        expect_val("sb_wb_busy_b0", B_B0, 32'h1);
        expect_val("sb_wb_data_b0", B_D0, 32'h0);
        expect_val("sb_wb_vec_same", A_V, 32'h0000_0200);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
        mem[9] = 32'h42;
        @(negedge clk);
        idle();
        #1;
        expect_val("sb_clr_vec_a", A_V, 32'h0);
        expect_val("sb_clr_vec_b", B_V, 32'h0);
        expect_val("sb_clr_data_b0", B_D0, mem[9]);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
    endtask

    task automatic test_collision_flush();
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd4; we = 1'b1; wa = 5'd4; wd = 32'h1;
        rd_addr0 = 5'd4; rd_addr1 = 5'd8;
        mem[4] = 32'h1;
        @(negedge clk);
        idle();
        #1;
        expect_val("col_vec", A_V, 32'h0000_0010);
        expect_val("col_data_a0", A_D0, mem[4]);
        expect_val("col_busy_a0", A_B0, 32'h1);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
        @(negedge clk);
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd6; we = 1'b1; wa = 5'd8; wd = 32'h88;
        mem[8] = 32'h88;
        @(negedge clk);
        idle();
        #1;
        expect_val("flush_vec_a", A_V, 32'h0);
        expect_val("flush_vec_b", B_V, 32'h0);
        expect_val("flush_keep_a0", A_D0, mem[4]);
        expect_val("flush_write_b1", B_D1, mem[8]);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vec_exp;
        vec_exp = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            we = 1'b1; wa = 5'(10 + i); wd = $urandom;
            iss_valid = 1'b1; iss_rd = 5'(20 + i);
            mem[10 + i] = wd;
            vec_exp[20 + i] = 1'b1;
        end
        @(negedge clk);
        idle();
        #1;
        expect_val("b2b_vec_a", A_V, vec_exp);
        expect_val("b2b_vec_b", B_V, vec_exp);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
        for (int i = 0; i < 4; i++) begin
            rd_addr0 = 5'(10 + 2 * i); rd_addr1 = 5'(11 + 2 * i);
            #1;
            expect_val("b2b_rd_a0", A_D0, mem[10 + 2 * i]);
            expect_val("b2b_rd_b1", B_D1, mem[11 + 2 * i]);
            while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
                if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
            end
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        idle();
        #1;
        expect_val("b2b_flush_vec", A_V, 32'h0);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd4;
        @(negedge clk);
        iss_rd = 5'd9;
        @(negedge clk);
        idle(); rd_addr0 = 5'd4; rd_addr1 = 5'd9;
        #1;
        expect_val("ar_vec_pre", A_V, 32'h0000_0210);
        expect_val("ar_data_pre", A_D0, mem[4]);
        expect_val("ar_busy_pre", A_B0, 32'h1);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
        #2;
        reset = 1'b0;
        #1;
        expect_val("ar_vec_a", A_V, 32'h0);
        expect_val("ar_vec_b", B_V, 32'h0);
        expect_val("ar_data_a0", A_D0, 32'h0);
        expect_val("ar_busy_a1", A_B1, 32'h0);
        expect_val("ar_data_b1", B_D1, 32'h0);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
        for (int r = 0; r < 32; r++) mem[r] = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        expect_val("ar_after_b1", B_D1, mem[9]);
        while (sb_q.size() > 0) begin e = sb_q.pop_front(); obs = observe(e.sel); n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp); end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) mem[r] = 32'h0;
        test_reset();
        test_write_latency();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_collision_flush();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle core's register file.
- Features: configurable data width and register count, NRD combinational read ports, one clocked write port, optional write-to-read bypass, hardwired zero register.
- Adds a per-register busy scoreboard for the upcoming pipelined core: the issue stage marks a destination busy; writeback clears it.
- Sits between decode/issue (reads, busy marking) and writeback (write, busy clear).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, >=2).
- AW, $clog2(NREGS), register address width (derived; not overridden).
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads see stored value only.
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, never busy; 0 = register 0 is ordinary.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- rd_addr  in  NRD*AW  read addresses; port i = bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port i = bits [i*XLEN +: XLEN].
- rd_busy  out  NRD  per-port busy flag for the addressed register.
- we  in  1  write enable (writeback).
- wa  in  AW  write address.
- wd  in  XLEN  write data.
- iss_valid  in  1  issue strobe; marks register iss_rd busy.
- iss_rd  in  AW  destination register being issued.
- flush  in  1  synchronous clear of all busy bits; data is kept.
- busy_vec  out  NREGS  full scoreboard, for debug and stall logic.

Behaviour:
- Reset (reset=0, asynchronous): all registers = 0, all busy bits = 0. Therefore rd_data = 0, rd_busy = 0, busy_vec = 0 while reset is low and after release. Writes and issues arriving during reset are discarded.
- Write: when we=1, wd is stored at the clk rising edge into reg[wa]. Through storage it is visible on reads from the next cycle.
- Read: combinational from rd_addr, with no clock latency. Each port is independent; all ports may address the same register.
- Bypass (BYPASS=1): if we=1 and wa==rd_addr[i] (and address !=0 when ZERO_REG=1), rd_data[i]=wd in the same cycle.
- Zero register (ZERO_REG=1):
  - Reads of address 0 return 0 on data and 0 on busy.
  - Writes to address 0 are dropped.
  - Issue to address 0 does not set busy.
- Scoreboard update at each rising edge, for each register r, in priority order:
  1. flush=1 → busy[r]=0. flush overrides same-cycle issue and write-clear; data writes still occur.
  2. iss_valid=1 and iss_rd==r → busy[r]=1. Issue wins over a same-cycle writeback to the same register, because the new producer supersedes the old one.
  3. we=1 and wa==r → busy[r]=0.
  4. Otherwise busy[r] holds.
- rd_busy[i]:
  - Reflects the stored busy[rd_addr[i]].
  - When BYPASS=1 and the same-cycle write matches the address, rd_busy[i]=0, since the forwarded data is valid.
  - Same-cycle issue does not affect rd_busy; it takes effect next cycle.
- busy_vec shows stored busy bits only, with no bypass.
- Writing a register that is not busy is legal: data is stored and busy stays 0.
- Out-of-range addresses cannot occur, because NREGS is a power of two.
- No $display or other simulation-only side effects in RTL.

Decomposition:
- Shared package regfile_pkg holds:
  - the default constants XLEN_DEF=32 and NREGS_DEF=32;
  - a function computing AW;
  - port-slicing helper functions for the flattened rd_addr and rd_data buses.
- One sub-module, regfile_rdport:
  - one combinational read port with zero-register and bypass muxing;
  - instantiated NRD times in a generate loop.
- Storage and scoreboard stay in the top module.

Test Plan:
- Reset: hold reset=0 for 2 cycles with we=1, wa=5, wd=32'hDEADBEEF → after release, rd_addr port0=5 reads 0 with rd_busy=0, and busy_vec=0.
- Write/read latency, BYPASS=0: write wa=3, wd=32'h12345678 → same cycle port0@3 reads 0; next cycle port0 and port1@3 read 32'h12345678.
- Bypass, BYPASS=1: we=1, wa=7, wd=32'hA5A5A5A5 with port1@7 → same cycle rd_data port1=32'hA5A5A5A5.
- Zero register: write wa=0, wd=32'hFFFFFFFF, and issue iss_rd=0 → port0@0 reads 0 with rd_busy=0 on all following cycles.
- Scoreboard:
  - issue iss_rd=9 → next cycle busy_vec[9]=1 and rd_busy=1 on a port addressing 9;
  - write wa=9, wd=32'h42 → in that cycle rd_busy=0 (BYPASS=1) and rd_data=32'h42; next cycle busy_vec[9]=0.
- Collision and flush:
  - same cycle iss_rd=4 and we=1, wa=4, wd=32'h1 → next cycle busy_vec[4]=1 and reg 4 holds 32'h1;
  - then flush=1 → next cycle busy_vec=0 and reg 4 still reads 32'h1.
- Async reset mid-operation: assert reset low between clock edges after busy_vec=32'h0000_0210 → outputs clear immediately, before the next edge.
